// File: rtl/vex_bus_arbiter.sv
// vex_bus_arbiter: shares one memory port between a VexRiscv-style iBus and dBus.
// Only one transaction is in flight at a time. Reads wait for a response, which
// is bounded by a timeout. Writes complete on the command handshake alone.
// Optional feature: define VEX_ARB_RR_EN to alternate the grant when both buses
// request in the same cycle. When it is undefined, dBus has fixed priority on ties.
module vex_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iBus_cmd_valid,
  output logic        iBus_cmd_ready,
  input  logic [31:0] iBus_cmd_payload_pc,
  output logic        iBus_rsp_valid,
  output logic        iBus_rsp_payload_error,
  output logic [31:0] iBus_rsp_payload_inst,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic        dBus_rsp_error,
  output logic [31:0] dBus_rsp_data,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_cmd_addr,
  output logic [31:0] mem_cmd_wdata,
  output logic [3:0]  mem_cmd_wstrb,
  input  logic        mem_rsp_valid,
  input  logic        mem_rsp_error,
  input  logic [31:0] mem_rsp_data
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    GNT_I  = 5'b00010,
    GNT_D  = 5'b00100,
    WAIT_I = 5'b01000,
    WAIT_D = 5'b10000
  } arbState_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  arbState_t   stateReg;
  logic [15:0] waitCntReg;

  logic inGntI, inGntD, inWaitI, inWaitD;
  logic tieToD, pickD;
  logic timeoutHit;
  logic [3:0] writeStrb;
  logic unusedPcLowBits;

  assign inGntI  = (stateReg == GNT_I);
  assign inGntD  = (stateReg == GNT_D);
  assign inWaitI = (stateReg == WAIT_I);
  assign inWaitD = (stateReg == WAIT_D);

  // Fetches are always word aligned, so the low pc bits carry no information here.
  assign unusedPcLowBits = ^iBus_cmd_payload_pc[1:0];

`ifdef VEX_ARB_RR_EN
  // 1 = dBus wins the next tie. It starts dBus-preferred and flips on every accepted command.
  logic preferDReg;
  assign tieToD = preferDReg;
`else
  assign tieToD = 1'b1;
`endif

  // A lone requester always wins. The tie-break only matters when both are valid.
  assign pickD = dBus_cmd_valid && (!iBus_cmd_valid || tieToD);

  // waitCntReg counts silent WAIT cycles already spent. The forced error goes out in
  // the cycle where that count equals the limit.
  assign timeoutHit = (waitCntReg == TIMEOUT_LIMIT);

  // Byte-lane enables for a dBus write. Each lane is decoded from size and the low address bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      localparam logic [1:0] LANE = 2'(gi);
      assign writeStrb[gi] = (dBus_cmd_payload_size == 2'd0) ? (dBus_cmd_payload_address[1:0] == LANE) :
                             (dBus_cmd_payload_size == 2'd1) ? (dBus_cmd_payload_address[1] == LANE[1]) :
                             1'b1;
    end
  endgenerate

  // Arbitration FSM, wait counter and tie-break pointer, all in one sequential block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= IDLE;
      waitCntReg <= '0;
`ifdef VEX_ARB_RR_EN
      preferDReg <= 1'b1;
`endif
    end else begin
      unique case (stateReg)
        IDLE: begin
          waitCntReg <= '0;
          if (iBus_cmd_valid || dBus_cmd_valid)
            stateReg <= pickD ? GNT_D : GNT_I;
        end
        GNT_I: begin
          if (!iBus_cmd_valid)
            stateReg <= IDLE;
          else if (mem_cmd_ready)
            stateReg <= WAIT_I;
        end
        GNT_D: begin
          if (!dBus_cmd_valid)
            stateReg <= IDLE;
          else if (mem_cmd_ready)
            stateReg <= dBus_cmd_payload_wr ? IDLE : WAIT_D;
        end
        WAIT_I, WAIT_D: begin
          if (mem_rsp_valid || timeoutHit) begin
            stateReg   <= IDLE;
            waitCntReg <= '0;
          end else begin
            waitCntReg <= waitCntReg + 16'd1;
          end
        end
        default: begin
          stateReg   <= IDLE;
          waitCntReg <= '0;
        end
      endcase
`ifdef VEX_ARB_RR_EN
      if ((inGntI && iBus_cmd_valid && mem_cmd_ready) ||
          (inGntD && dBus_cmd_valid && mem_cmd_ready))
        preferDReg <= !preferDReg;
`endif
    end
  end

  assign mem_cmd_valid  = inGntI || inGntD;
  assign iBus_cmd_ready = inGntI && mem_cmd_ready;
  assign dBus_cmd_ready = inGntD && mem_cmd_ready;

  // Forward the granted bus's command to the memory port. Outside a grant it drives zeros.
  always_comb begin
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    mem_cmd_wstrb = '0;
    if (inGntI) begin
      mem_cmd_addr = {iBus_cmd_payload_pc[31:2], 2'b00};
    end else if (inGntD) begin
      mem_cmd_addr = {dBus_cmd_payload_address[31:2], 2'b00};
      if (dBus_cmd_payload_wr) begin
        mem_cmd_wdata = dBus_cmd_payload_data;
        mem_cmd_wstrb = writeStrb;
      end
    end
  end

  // Responses pass through in the same cycle. A real response beats a coinciding timeout.
  // Response outputs drive zeros unless the matching WAIT state is active.
  assign iBus_rsp_valid         = inWaitI && (mem_rsp_valid || timeoutHit);
  assign iBus_rsp_payload_error = inWaitI && (mem_rsp_valid ? mem_rsp_error : timeoutHit);
  assign iBus_rsp_payload_inst  = (inWaitI && mem_rsp_valid) ? mem_rsp_data : 32'h0;

  assign dBus_rsp_ready = inWaitD && (mem_rsp_valid || timeoutHit);
  assign dBus_rsp_error = inWaitD && (mem_rsp_valid ? mem_rsp_error : timeoutHit);
  assign dBus_rsp_data  = (inWaitD && mem_rsp_valid) ? mem_rsp_data : 32'h0;

endmodule

// File: doc/vex_bus_arbiter.md
VEX_BUS_ARBITER -- requirements
Module: vex_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of response-wait cycles before an error response is forced (range 1..65535).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iBus_cmd_valid  in  1  CPU fetch request.
- iBus_cmd_ready  out  1  fetch request accepted.
- iBus_cmd_payload_pc  in  32  fetch address.
- iBus_rsp_valid  out  1  fetch response strobe.
- iBus_rsp_payload_error  out  1  fetch error.
- iBus_rsp_payload_inst  out  32  fetched word.
- dBus_cmd_valid  in  1  CPU data request.
- dBus_cmd_ready  out  1  data request accepted.
- dBus_cmd_payload_wr  in  1  1 = write.
- dBus_cmd_payload_address  in  32  data address.
- dBus_cmd_payload_data  in  32  write data, already lane-replicated.
- dBus_cmd_payload_size  in  2  0 = byte, 1 = half, 2 = word.
- dBus_rsp_ready  out  1  read response strobe.
- dBus_rsp_error  out  1  read error.
- dBus_rsp_data  out  32  read word.
- mem_cmd_valid  out  1  shared-port request.
- mem_cmd_ready  in  1  shared-port accept.
- mem_cmd_addr  out  32  word-aligned address: addr[31:2], 2'b00.
- mem_cmd_wdata  out  32  write data.
- mem_cmd_wstrb  out  4  byte enables; 0 = read.
- mem_rsp_valid  in  1  read response strobe.
- mem_rsp_error  in  1  read error.
- mem_rsp_data  in  32  read word.

Function
REQ-003 SHALL use a one-hot FSM with states IDLE, GNT_I, GNT_D, WAIT_I and WAIT_D, and SHALL allow at most one transaction outstanding.
REQ-004 In IDLE, SHALL pick a requester from the registered grant decision, so mem_cmd_valid rises no earlier than the cycle after the CPU valid is first seen.
REQ-005 When both requesters are valid in IDLE, SHALL grant per REQ-020; a lone requester is always granted.
REQ-006 In GNT_x, SHALL drive mem_cmd_valid=1 with the payload taken combinationally from bus x, and x_cmd_ready = mem_cmd_ready; the other bus's cmd_ready SHALL be 0.
REQ-007 SHALL set wstrb for reads and iBus to 4'h0; for writes: size 0 -> 4'b0001<<addr[1:0], size 1 -> 4'b0011<<{addr[1],1'b0}, size 2/3 -> 4'hF.
REQ-008 On handshake in GNT_I or GNT_D-read, SHALL go to WAIT_x; on handshake in GNT_D-write, SHALL return to IDLE with no CPU response.
REQ-009 In WAIT_x, SHALL forward mem_rsp_valid, error and data to bus x's response in the same cycle (zero-latency, combinational), then go to IDLE.
REQ-010 SHALL count WAIT cycles in a 16-bit counter; when the counter reaches TIMEOUT_CYCLES without a response, SHALL emit one x response with error=1 and data=0, then go to IDLE.
REQ-011 If mem_rsp_valid and timeout occur in the same cycle, the real response SHALL win and error SHALL be mem_rsp_error.
REQ-012 SHALL ignore mem_rsp_valid outside WAIT states; it SHALL produce no CPU response.
REQ-013 SHALL never assert iBus_rsp_valid and dBus_rsp_ready in the same cycle.
REQ-014 A CPU valid that drops before handshake in GNT_x (illegal) SHALL return the FSM to IDLE next cycle.

Reset
REQ-015 While reset=0, SHALL hold FSM=IDLE, counter=0 and round-robin pointer=dBus-preferred.
REQ-016 While reset=0, SHALL drive all outputs to 0: mem_cmd_valid, cmd_ready, rsp strobes, error and data.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction with no response; after release, the first grant SHALL follow a full IDLE cycle.
REQ-018 Reset release SHALL be synchronised externally; the block SHALL assume no recovery timing of its own.

Configuration
REQ-019 Macro VEX_ARB_RR_EN SHALL select the tie-break policy.
REQ-020 With VEX_ARB_RR_EN defined: alternate the grant on ties, with the pointer flipping after each granted handshake. Without it: dBus always wins ties (fixed priority), and the pointer logic is absent.

Verification
REQ-021 Single fetch: iBus pc=0x100, mem accepts at once, rsp 2 cycles later data=0x00000013 -> iBus_rsp_valid one cycle with inst=0x00000013, error=0.
REQ-022 Byte write: addr=0x203, size=0, data=0xAAAAAAAA -> mem_cmd_addr=0x200, wstrb=4'b1000, no dBus_rsp_ready, FSM in IDLE next cycle.
REQ-023 Simultaneous iBus+dBus valid, 4 back-to-back ties -> without macro dBus granted 4 times first; with macro the grant order is D, I, D, I.
REQ-024 TIMEOUT_CYCLES=4, dBus read, no mem_rsp -> dBus_rsp_ready with error=1, data=0 after 4 WAIT cycles; a late mem_rsp_valid is ignored.
REQ-025 Timeout and mem_rsp_valid coincide with data=0x12345678, error=0 -> response data=0x12345678, error=0.
REQ-026 reset pulled low in WAIT_I -> no iBus_rsp_valid, all outputs 0 during reset, next fetch is served normally.
